ibex_pmp_iter: RTL and testbench
================================

# ibex_pmp_iter

Multi-cycle, handshaked PMP checker and parametrised successor to the single-cycle combinational PMP check. Each channel accepts one request at a time and scans regions in groups of `RegionsPerCycle` per cycle, lowest index first. It stops at the first matching region and returns the verdict, the deciding region index and a match flag over a valid/ready response. It sits between the core's fetch/LSU request paths and the CSR file, and trades latency for area and timing on large region counts.

## Interface
Parameters:
- `PMPGranularity`, 0: NAPOT/TOR granule is 2^(G+2) bytes.
- `PMPNumChan`, 2: independent access channels.
- `PMPNumRegions`, 16: implemented regions, 1..16.
- `RegionsPerCycle`, 4: regions evaluated per scan cycle.
  - Must divide `PMPNumRegions`.
  - `NumGroups = PMPNumRegions/RegionsPerCycle`.

Ports (`RegIdxW = $clog2(PMPNumRegions)+1`):
- `clk_i` in 1: clock.
- `rst_i` in 1: reset, asynchronous, active-high.
- `csr_pmp_cfg_i` in `pmp_cfg_t [PMPNumRegions]`: region configs.
- `csr_pmp_addr_i` in 34 `[PMPNumRegions]`: region addresses, byte address bits 33:0.
- `csr_pmp_mseccfg_i` in `pmp_mseccfg_t`: MML, MMWP. RLB is unused.
- `csr_pmp_update_i` in 1: pulse on any PMP CSR write.
- `req_valid_i` in `[PMPNumChan]`: request valid.
- `req_ready_o` out `[PMPNumChan]`: request ready.
- `req_addr_i` in 34 `[PMPNumChan]`: request address.
- `req_type_i` in `pmp_req_e [PMPNumChan]`: EXEC, WRITE or READ.
- `priv_mode_i` in `priv_lvl_e [PMPNumChan]`: privilege level of the request.
- `rsp_valid_o` out `[PMPNumChan]`: response valid.
- `rsp_ready_i` in `[PMPNumChan]`: response ready.
- `rsp_err_o` out `[PMPNumChan]`: 1 = access fault.
- `rsp_region_o` out `RegIdxW [PMPNumChan]`: deciding region; `PMPNumRegions` = no match.

## Operation
Each channel runs an independent FSM with states IDLE, SCAN and RESP.
- **IDLE**
  - `req_ready_o`=1.
  - On `req_valid_i` the channel latches addr, type and priv, sets group=0 and moves to SCAN.
- **SCAN**
  - Each cycle, evaluate regions `group*RegionsPerCycle` .. `+RegionsPerCycle-1` against live CSR inputs.
  - If any region matches: latch the lowest matching index, compute err, and move to RESP.
  - Else if group = `NumGroups-1`: no match; region = `PMPNumRegions`; move to RESP.
    - Default err = MMWP | (priv != M).
  - Else group++.
  - If `csr_pmp_update_i`=1: discard this cycle's result and set group=0. The update takes priority over match and completion.
- **RESP**
  - `rsp_valid_o`=1. Outputs are registered and stable until `rsp_ready_i`=1, then return to IDLE.
  - `csr_pmp_update_i` is ignored in RESP.

Matching semantics per region:
- OFF never matches.
- NA4 and NAPOT: masked equality. The NAPOT mask is derived from trailing ones of pmpaddr above the granule.
- TOR: `addr_{r-1}` <= a < `addr_r`, with `addr_{-1}`=0.
- All comparisons use bits [33:G+2].

Permission rules:
- With MML=0:
  - M-mode: allow if L=0 or the R/W/X bit for the access type is set.
  - Other modes: R/W/X bit only.
- With MML=1, R=0 W=1 is a shared region, decided on {L,X}:
  - 00: R all modes, W M-mode only.
  - 01: R/W all modes.
  - 10: X all modes.
  - 11: X all modes, R M-mode only.
- With MML=1, R=W=X=L=1: read-only for all modes.
- With MML=1, otherwise:
  - M-mode requires L=1 and the permission bit.
  - Other modes require L=0 and the permission bit.

Channels share only the CSR inputs. Simultaneous requests on all channels proceed fully in parallel.

## Timing
- Handshake occurs in cycle 0. Group g is evaluated in cycle g+1. With a match in group g, `rsp_valid_o` rises in cycle g+2.
- Minimum latency is 2 cycles; maximum is `NumGroups+1`.
- Each `csr_pmp_update_i` seen in SCAN adds the number of groups already scanned.
- `req_ready_o` is low from cycle 1 until the cycle after the response handshake. Peak throughput is 1 request per latency+1 cycles per channel.
- Reset (async assert, sync deassert expected upstream):
  - All FSMs go to IDLE.
  - `rsp_valid_o`=0, `rsp_err_o`=0, `rsp_region_o`=0.
  - `req_ready_o`=0 while `rst_i`=1.
  - Reset mid-SCAN or mid-RESP drops the request silently.
- `req_*` inputs are don't-care outside the IDLE handshake. `rsp_ready_i` is don't-care outside RESP.

## Configuration
`IBEX_PMP_ITER_CONST_LATENCY_EN`:
- When defined:
  - SCAN always runs all `NumGroups` groups and keeps the first match found.
  - `rsp_valid_o` rises in exactly cycle `NumGroups+1` regardless of match position.
  - A CSR update restarts the full scan. This removes the timing side channel.
- When undefined: early exit, as described under Operation.

## Test plan
Setup for all cases: 16 regions, 4 per cycle, G=0, early exit unless stated.
- Region0 NAPOT `pmpaddr`=0x200001FF, R=1. M-mode read 0x8000_0010 -> rsp in cycle 2, err=0, region=0.
- Only region13 TOR (addr12=0x400, addr13=0x800, R=1, X=0). U-mode exec 0x1800 -> rsp in cycle 5, err=1, region=13.
- All regions OFF, MMWP=0:
  - U-mode read -> err=1, region=16, cycle 5.
  - M-mode read -> err=0.
  - With MMWP=1, M-mode read -> err=1.
- Pulse `csr_pmp_update_i` in cycle 2 of the region13 case while also turning region1 on to match -> restart; rsp in cycle 4, region=1.
- Hold `rsp_ready_i`=0 for 3 cycles -> outputs stable and `req_ready_o`=0. Run both channels concurrently with different latencies -> independent, correct results. Assert `rst_i` mid-SCAN -> `rsp_valid_o`=0, channel IDLE.
- MML=1, region R=0 W=1 X=0 L=1:
  - M-mode exec -> err=0.
  - M-mode read -> err=1.
  - With `IBEX_PMP_ITER_CONST_LATENCY_EN`, the region0 case responds in cycle 5.

Source files
------------

// File: rtl/ibex_pmp_iter.sv
// ibex_pmp_iter: multi-cycle PMP checker, regions scanned in groups over valid/ready.
// Option: IBEX_PMP_ITER_CONST_LATENCY_EN always scans every group (fixed latency).
package ibex_pmp_iter_pkg;

    typedef enum logic [1:0] {
        PMP_MODE_OFF   = 2'b00,
        PMP_MODE_TOR   = 2'b01,
        PMP_MODE_NA4   = 2'b10,
        PMP_MODE_NAPOT = 2'b11
    } pmp_cfg_mode_e;

    typedef struct packed {
        logic          lock;
        pmp_cfg_mode_e mode;
        logic          exec;
        logic          write;
        logic          read;
    } pmp_cfg_t;

    typedef struct packed {
        logic rlb;
        logic mmwp;
        logic mml;
    } pmp_mseccfg_t;

    typedef enum logic [1:0] {
        PMP_ACC_EXEC  = 2'b00,
        PMP_ACC_WRITE = 2'b01,
        PMP_ACC_READ  = 2'b10
    } pmp_req_e;

    typedef enum logic [1:0] {
        PRIV_LVL_M = 2'b11,
        PRIV_LVL_H = 2'b10,
        PRIV_LVL_S = 2'b01,
        PRIV_LVL_U = 2'b00
    } priv_lvl_e;

endpackage

module ibex_pmp_iter
    import ibex_pmp_iter_pkg::*;
#(
    parameter int unsigned PMPGranularity  = 0,
    parameter int unsigned PMPNumChan      = 2,
    parameter int unsigned PMPNumRegions   = 16,
    parameter int unsigned RegionsPerCycle = 4,
    localparam int unsigned RegIdxW = $clog2(PMPNumRegions) + 1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  pmp_cfg_t           csr_pmp_cfg_i     [PMPNumRegions],
    input  logic [33:0]        csr_pmp_addr_i    [PMPNumRegions],
    input  pmp_mseccfg_t       csr_pmp_mseccfg_i,
    input  logic               csr_pmp_update_i,
    input  logic               req_valid_i       [PMPNumChan],
    output logic               req_ready_o       [PMPNumChan],
    input  logic [33:0]        req_addr_i        [PMPNumChan],
    input  pmp_req_e           req_type_i        [PMPNumChan],
    input  priv_lvl_e          priv_mode_i       [PMPNumChan],
    output logic               rsp_valid_o       [PMPNumChan],
    input  logic               rsp_ready_i       [PMPNumChan],
    output logic               rsp_err_o         [PMPNumChan],
    output logic [RegIdxW-1:0] rsp_region_o      [PMPNumChan]
);

    localparam int unsigned NumGroups = PMPNumRegions / RegionsPerCycle;
    localparam int unsigned GrpW  = (NumGroups > 1) ? $clog2(NumGroups) : 1;
    localparam int unsigned RegAW = (PMPNumRegions > 1) ? $clog2(PMPNumRegions) : 1;
    localparam int unsigned Lsb   = PMPGranularity + 2;
    localparam logic [GrpW-1:0]    LastGrp = GrpW'(NumGroups - 1);
    localparam logic [RegIdxW-1:0] NoMatch = RegIdxW'(PMPNumRegions);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        SCAN = 2'b01,
        RESP = 2'b10
    } state_e;

    logic unused_rlb;
    assign unused_rlb = csr_pmp_mseccfg_i.rlb;

    function automatic logic region_match(
        input logic [RegAW-1:0] r,
        input logic [33:0]      a
    );
        pmp_cfg_t    cfg;
        logic [33:0] base;
        logic [33:0] top;
        logic [33:0] mask;
        logic        napot;
        logic        ones;
        cfg   = csr_pmp_cfg_i[r];
        top   = csr_pmp_addr_i[r];
        base  = (r == '0) ? '0 : csr_pmp_addr_i[r - 1'b1];
        napot = (cfg.mode == PMP_MODE_NAPOT);
        mask  = '0;
        ones  = 1'b1;
        // NAPOT size comes from the run of ones just above the granule
        for (int b = Lsb; b < 34; b++) begin
            if (b == Lsb) begin
                mask[b] = ~napot;
            end else begin
                ones    = ones & top[b-1];
                mask[b] = ~napot | ~ones;
            end
        end
        unique case (cfg.mode)
            PMP_MODE_TOR:
                region_match = ((a >> Lsb) >= (base >> Lsb)) &&
                               ((a >> Lsb) <  (top >> Lsb));
            PMP_MODE_NA4, PMP_MODE_NAPOT:
                region_match = (((a ^ top) & mask) == '0);
            default:
                region_match = 1'b0;
        endcase
    endfunction

    function automatic logic perm_ok(
        input pmp_cfg_t  cfg,
        input pmp_req_e  t,
        input priv_lvl_e p
    );
        logic m, rd, wr, ex, bit_ok, mml;
        m      = (p == PRIV_LVL_M);
        rd     = (t == PMP_ACC_READ);
        wr     = (t == PMP_ACC_WRITE);
        ex     = (t == PMP_ACC_EXEC);
        mml    = csr_pmp_mseccfg_i.mml;
        bit_ok = (rd & cfg.read) | (wr & cfg.write) | (ex & cfg.exec);
        unique case (1'b1)
            ~mml:
                perm_ok = m ? (~cfg.lock | bit_ok) : bit_ok;
            mml & ~cfg.read & cfg.write: begin
                unique case ({cfg.lock, cfg.exec})
                    2'b00:   perm_ok = rd | (wr & m);
                    2'b01:   perm_ok = rd | wr;
                    2'b10:   perm_ok = ex;
                    default: perm_ok = ex | (rd & m);
                endcase
            end
            mml & cfg.read & cfg.write & cfg.exec & cfg.lock:
                perm_ok = rd;
            default:
                perm_ok = (m ? cfg.lock : ~cfg.lock) & bit_ok;
        endcase
    endfunction

    for (genvar c = 0; c < PMPNumChan; c++) begin : g_chan
        state_e             state_q, state_d;
        logic [33:0]        addr_q;
        pmp_req_e           type_q;
        priv_lvl_e          priv_q;
        logic [GrpW-1:0]    grp_q, grp_d;
        logic               err_q, err_d;
        logic [RegIdxW-1:0] region_q, region_d;
        logic               hit, hit_err, def_err;
        logic [RegIdxW-1:0] hit_idx;
        logic               take, ready, valid;
`ifdef IBEX_PMP_ITER_CONST_LATENCY_EN
        logic               found_q, found_d;
`endif

        assign take = (state_q == IDLE) & req_valid_i[c];

        // lowest matching index within the current group wins
        always_comb begin
            int unsigned base_idx;
            int unsigned idx;
            hit      = 1'b0;
            hit_idx  = '0;
            base_idx = 32'(grp_q) * RegionsPerCycle;
            for (int i = RegionsPerCycle - 1; i >= 0; i--) begin
                idx = base_idx + unsigned'(i);
                if (region_match(RegAW'(idx), addr_q)) begin
                    hit     = 1'b1;
                    hit_idx = RegIdxW'(idx);
                end
            end
            hit_err = ~perm_ok(csr_pmp_cfg_i[RegAW'(hit_idx)], type_q, priv_q);
            def_err = csr_pmp_mseccfg_i.mmwp | (priv_q != PRIV_LVL_M);
        end

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                state_q  <= IDLE;
                addr_q   <= '0;
                type_q   <= PMP_ACC_EXEC;
                priv_q   <= PRIV_LVL_M;
                grp_q    <= '0;
                err_q    <= 1'b0;
                region_q <= '0;
`ifdef IBEX_PMP_ITER_CONST_LATENCY_EN
                found_q  <= 1'b0;
`endif
            end else begin
                state_q  <= state_d;
                grp_q    <= grp_d;
                err_q    <= err_d;
                region_q <= region_d;
`ifdef IBEX_PMP_ITER_CONST_LATENCY_EN
                found_q  <= found_d;
`endif
                if (take) begin
                    addr_q <= req_addr_i[c];
                    type_q <= req_type_i[c];
                    priv_q <= priv_mode_i[c];
                end
            end
        end

        always_comb begin
            state_d  = state_q;
            grp_d    = grp_q;
            err_d    = err_q;
            region_d = region_q;
`ifdef IBEX_PMP_ITER_CONST_LATENCY_EN
            found_d  = found_q;
`endif
            unique case (state_q)
                IDLE: begin
                    if (req_valid_i[c]) begin
                        state_d = SCAN;
                        grp_d   = '0;
`ifdef IBEX_PMP_ITER_CONST_LATENCY_EN
                        found_d = 1'b0;
`endif
                    end
                end
                SCAN: begin
`ifdef IBEX_PMP_ITER_CONST_LATENCY_EN
                    if (csr_pmp_update_i) begin
                        grp_d   = '0;
                        found_d = 1'b0;
                    end else begin
                        if (hit && !found_q) begin
                            found_d  = 1'b1;
                            err_d    = hit_err;
                            region_d = hit_idx;
                        end
                        if (grp_q == LastGrp) begin
                            state_d = RESP;
                            if (!found_q && !hit) begin
                                err_d    = def_err;
                                region_d = NoMatch;
                            end
                        end else begin
                            grp_d = grp_q + GrpW'(1);
                        end
                    end
`else
                    if (csr_pmp_update_i) begin
                        grp_d = '0;
                    end else if (hit) begin
                        state_d  = RESP;
                        err_d    = hit_err;
                        region_d = hit_idx;
                    end else if (grp_q == LastGrp) begin
                        state_d  = RESP;
                        err_d    = def_err;
                        region_d = NoMatch;
                    end else begin
                        grp_d = grp_q + GrpW'(1);
                    end
`endif
                end
                RESP: begin
                    if (rsp_ready_i[c]) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        always_comb begin
            ready = 1'b0;
            valid = 1'b0;
            unique case (state_q)
                IDLE:    ready = ~rst_i;
                RESP:    valid = 1'b1;
                default: ;
            endcase
        end

        assign req_ready_o[c]  = ready;
        assign rsp_valid_o[c]  = valid;
        assign rsp_err_o[c]    = err_q;
        assign rsp_region_o[c] = region_q;
    end

endmodule

// File: tb/tb_ibex_pmp_iter.sv
// tb_ibex_pmp_iter: directed vectors for ibex_pmp_iter (16 regions, 4 per cycle, G=0).
// Expected latencies follow IBEX_PMP_ITER_CONST_LATENCY_EN when it is defined.
module tb_ibex_pmp_iter;
    import ibex_pmp_iter_pkg::*;

    localparam int RW = 5;
`ifdef IBEX_PMP_ITER_CONST_LATENCY_EN
    localparam bit CL = 1'b1;
`else
    localparam bit CL = 1'b0;
`endif

    logic         clk;
    logic         rst;
    pmp_cfg_t     cfg        [16];
    logic [33:0]  addr       [16];
    pmp_mseccfg_t msec;
    logic         csr_update;
    logic         req_valid  [2];
    logic         req_ready  [2];
    logic [33:0]  req_addr   [2];
    pmp_req_e     req_type   [2];
    priv_lvl_e    priv       [2];
    logic         rsp_valid  [2];
    logic         rsp_ready  [2];
    logic         rsp_err    [2];
    logic [RW-1:0] rsp_region [2];

    pmp_cfg_t    upd_cfg;
    logic [33:0] upd_addr;
    int n_chk;
    int n_fail;

    ibex_pmp_iter dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .csr_pmp_cfg_i     (cfg),
        .csr_pmp_addr_i    (addr),
        .csr_pmp_mseccfg_i (msec),
        .csr_pmp_update_i  (csr_update),
        .req_valid_i       (req_valid),
        .req_ready_o       (req_ready),
        .req_addr_i        (req_addr),
        .req_type_i        (req_type),
        .priv_mode_i       (priv),
        .rsp_valid_o       (rsp_valid),
        .rsp_ready_i       (rsp_ready),
        .rsp_err_o         (rsp_err),
        .rsp_region_o      (rsp_region)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic pmp_cfg_t mk(input logic l, input pmp_cfg_mode_e m,
                                    input logic x, input logic w, input logic r);
        pmp_cfg_t v;
        v.lock  = l;
        v.mode  = m;
        v.exec  = x;
        v.write = w;
        v.read  = r;
        return v;
    endfunction

    task automatic clr();
        for (int i = 0; i < 16; i++) begin
            cfg[i]  = mk(1'b0, PMP_MODE_OFF, 1'b0, 1'b0, 1'b0);
            addr[i] = '0;
        end
        msec = '0;
    endtask

    task automatic run(
        input logic en0, input logic en1,
        input logic [33:0] a0, input logic [33:0] a1,
        input pmp_req_e t0, input pmp_req_e t1,
        input priv_lvl_e p0, input priv_lvl_e p1,
        input logic e0, input logic e1,
        input int r0, input int r1,
        input int l0, input int l1,
        input int upd, input int stall
    );
        logic en [2];
        logic seen [2];
        logic er [2];
        int   lat [2];
        int   rg [2];
        int   held;
        en[0] = en0;
        en[1] = en1;
        for (int c = 0; c < 2; c++) begin
            seen[c] = 1'b0;
            er[c]   = 1'b0;
            lat[c]  = 0;
            rg[c]   = 0;
        end
        held = 0;
        @(negedge clk);
        rsp_ready[0] = (stall == 0);
        rsp_ready[1] = 1'b1;
        req_valid[0] = en0; req_addr[0] = a0; req_type[0] = t0; priv[0] = p0;
        req_valid[1] = en1; req_addr[1] = a1; req_type[1] = t1; priv[1] = p1;
        for (int c = 0; c < 2; c++)
            if (en[c]) chk("req_ready_idle", req_ready[c], 1);
        @(posedge clk);
        @(negedge clk);
        req_valid[0] = 1'b0;
        req_valid[1] = 1'b0;
        for (int c = 0; c < 2; c++)
            if (en[c]) chk("req_ready_busy", req_ready[c], 0);
        for (int cyc = 1; cyc <= 24; cyc++) begin
            csr_update = (cyc == upd);
            if (cyc == upd) begin
                cfg[1]  = upd_cfg;
                addr[1] = upd_addr;
            end
            for (int c = 0; c < 2; c++) begin
                if (en[c] && !seen[c] && rsp_valid[c]) begin
                    seen[c] = 1'b1;
                    lat[c]  = cyc;
                    er[c]   = rsp_err[c];
                    rg[c]   = int'(rsp_region[c]);
                end
            end
            if (stall > 0 && seen[0] && cyc > lat[0] && held < stall) begin
                chk("hold_valid", rsp_valid[0], 1);
                chk("hold_err", rsp_err[0], e0);
                chk("hold_region", rsp_region[0], r0);
                chk("hold_req_ready", req_ready[0], 0);
                held++;
                if (held == stall) rsp_ready[0] = 1'b1;
            end
            if ((!en[0] || seen[0]) && (!en[1] || seen[1]) &&
                (stall == 0 || held == stall)) break;
            @(posedge clk);
            @(negedge clk);
        end
        csr_update = 1'b0;
        @(posedge clk);
        @(negedge clk);
        for (int c = 0; c < 2; c++) begin
            if (en[c]) begin
                chk("back_idle_ready", req_ready[c], 1);
                chk("back_idle_valid", rsp_valid[c], 0);
            end
        end
        if (en0) begin
            chk("ch0_latency", lat[0], l0);
            chk("ch0_err", er[0], e0);
            chk("ch0_region", rg[0], r0);
        end
        if (en1) begin
            chk("ch1_latency", lat[1], l1);
            chk("ch1_err", er[1], e1);
            chk("ch1_region", rg[1], r1);
        end
    endtask

    task automatic one(input logic [33:0] a, input pmp_req_e t, input priv_lvl_e p,
                       input logic e, input int r, input int l);
        run(1'b1, 1'b0, a, '0, t, PMP_ACC_READ, p, PRIV_LVL_M,
            e, 1'b0, r, 0, l, 0, 0, 0);
    endtask

    task automatic set_r0();
        cfg[0]  = mk(1'b0, PMP_MODE_NAPOT, 1'b0, 1'b0, 1'b1);
        addr[0] = 34'h0_8000_07FC;
    endtask

    task automatic set_r13();
        cfg[13]  = mk(1'b0, PMP_MODE_TOR, 1'b0, 1'b0, 1'b1);
        addr[12] = 34'h1000;
        addr[13] = 34'h2000;
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        rst = 1'b1;
        csr_update = 1'b0;
        upd_cfg = '0;
        upd_addr = '0;
        for (int c = 0; c < 2; c++) begin
            req_valid[c] = 1'b0;
            req_addr[c]  = '0;
            req_type[c]  = PMP_ACC_READ;
            priv[c]      = PRIV_LVL_M;
            rsp_ready[c] = 1'b1;
        end
        clr();
        repeat (2) @(negedge clk);
        for (int c = 0; c < 2; c++) begin
            chk("rst_req_ready", req_ready[c], 0);
            chk("rst_rsp_valid", rsp_valid[c], 0);
            chk("rst_rsp_err", rsp_err[c], 0);
            chk("rst_rsp_region", rsp_region[c], 0);
        end
        rst = 1'b0;

        set_r0();
        one(34'h0_8000_0010, PMP_ACC_READ, PRIV_LVL_M, 1'b0, 0, CL ? 5 : 2);

        clr();
        set_r13();
        one(34'h1800, PMP_ACC_EXEC, PRIV_LVL_U, 1'b1, 13, 5);

        @(negedge clk);
        req_valid[0] = 1'b1;
        req_addr[0]  = 34'h1800;
        req_type[0]  = PMP_ACC_READ;
        priv[0]      = PRIV_LVL_U;
        @(posedge clk);
        @(negedge clk);
        req_valid[0] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midscan_rst_valid", rsp_valid[0], 0);
        chk("midscan_rst_ready", req_ready[0], 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", req_ready[0], 1);
        chk("post_rst_region", rsp_region[0], 0);
        chk("post_rst_err", rsp_err[0], 0);
        repeat (6) @(negedge clk);
        chk("dropped_valid", rsp_valid[0], 0);
        chk("dropped_ready", req_ready[0], 1);

        clr();
        one(34'h1234, PMP_ACC_READ, PRIV_LVL_U, 1'b1, 16, 5);
        one(34'h1234, PMP_ACC_READ, PRIV_LVL_M, 1'b0, 16, 5);
        msec.mmwp = 1'b1;
        one(34'h1234, PMP_ACC_READ, PRIV_LVL_M, 1'b1, 16, 5);

        clr();
        set_r13();
        upd_cfg  = mk(1'b0, PMP_MODE_NA4, 1'b1, 1'b0, 1'b0);
        upd_addr = 34'h1800;
        run(1'b1, 1'b0, 34'h1800, '0, PMP_ACC_EXEC, PMP_ACC_READ,
            PRIV_LVL_U, PRIV_LVL_M, 1'b0, 1'b0, 1, 0, CL ? 7 : 4, 0, 2, 0);

        clr();
        set_r0();
        run(1'b1, 1'b0, 34'h0_8000_0010, '0, PMP_ACC_READ, PMP_ACC_READ,
            PRIV_LVL_M, PRIV_LVL_M, 1'b0, 1'b0, 0, 0, CL ? 5 : 2, 0, 0, 3);

        set_r13();
        run(1'b1, 1'b1, 34'h0_8000_0010, 34'h1800, PMP_ACC_READ, PMP_ACC_EXEC,
            PRIV_LVL_M, PRIV_LVL_U, 1'b0, 1'b1, 0, 13, CL ? 5 : 2, 5, 0, 0);

        clr();
        msec.mml = 1'b1;
        cfg[0]  = mk(1'b1, PMP_MODE_NAPOT, 1'b0, 1'b1, 1'b0);
        addr[0] = 34'h0_8000_07FC;
        one(34'h0_8000_0010, PMP_ACC_EXEC, PRIV_LVL_M, 1'b0, 0, CL ? 5 : 2);
        one(34'h0_8000_0010, PMP_ACC_READ, PRIV_LVL_M, 1'b1, 0, CL ? 5 : 2);
        one(34'h0_8000_0010, PMP_ACC_EXEC, PRIV_LVL_U, 1'b0, 0, CL ? 5 : 2);
        cfg[0]  = mk(1'b1, PMP_MODE_NAPOT, 1'b1, 1'b1, 1'b1);
        one(34'h0_8000_0010, PMP_ACC_READ, PRIV_LVL_U, 1'b0, 0, CL ? 5 : 2);
        one(34'h0_8000_0010, PMP_ACC_WRITE, PRIV_LVL_M, 1'b1, 0, CL ? 5 : 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
